// File: rtl/sand_spawn_if.sv
// Bus bundle for sand_spawn: the HPS kernel register port plus the shared
// SDRAM master port with its req/grant handshake.
interface sand_spawn_if;
    logic        kernel_chipselect;
    logic        kernel_write;
    logic [2:0]  kernel_address;
    logic [15:0] kernel_writedata;

    logic        mem_req;
    logic        mem_grant;
    logic [23:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [15:0] mem_readdata;

    // Injector side: takes kernel writes, masters the SDRAM.
    modport slave (
        input  kernel_chipselect, kernel_write, kernel_address, kernel_writedata,
        input  mem_grant, mem_waitrequest, mem_readdatavalid, mem_readdata,
        output mem_req, mem_address, mem_read, mem_write, mem_writedata
    );

    // Environment side: HPS writer, arbiter and SDRAM.
    modport master (
        output kernel_chipselect, kernel_write, kernel_address, kernel_writedata,
        output mem_grant, mem_waitrequest, mem_readdatavalid, mem_readdata,
        input  mem_req, mem_address, mem_read, mem_write, mem_writedata
    );
endinterface

// File: rtl/sand_spawn.sv
// Particle injector: queues "place cell (x, y, type)" commands from the HPS
// and applies each one as a read-modify-write of the 16-bit grid word that
// holds the cell (8 cells of 2 bits per word, cell 0 in the MSBs).
module sand_spawn #(
    parameter logic [23:0] BASE_ADDR  = 24'h0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    sand_spawn_if.slave bus,
    output logic        busy,
    output logic        overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {IDLE, REQ, RD, RWAIT, WR, DONE} state_t;

    // Kernel-visible registers
    logic [9:0] x_reg;
    logic [8:0] y_reg;
    logic [1:0] t_reg;
    logic       overflow_reg;

    // Command queue: {x, y, type}
    logic [20:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    // Working latch for the command being applied
    logic [23:0] work_addr_reg;
    logic [2:0]  work_cell_reg;
    logic [1:0]  work_type_reg;

    // FSM and registered bus outputs
    state_t      state_reg, state_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_read_reg, mem_read_next;
    logic        mem_write_reg, mem_write_next;
    logic [23:0] mem_address_reg, mem_address_next;
    logic [15:0] mem_writedata_reg, mem_writedata_next;

    logic        reg_wr;
    logic        commit;
    logic        clear_ovf;
    logic        in_range;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        drop_ovf;
    logic [20:0] head;
    logic [15:0] merged_word;
    logic        unused_writedata;

    assign reg_wr     = bus.kernel_chipselect & bus.kernel_write;
    assign commit     = reg_wr && (bus.kernel_address == 3'd3);
    assign clear_ovf  = reg_wr && (bus.kernel_address == 3'd4);
    assign in_range   = (x_reg < 10'd640) && (y_reg < 9'd480);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_FULL);
    // The head entry stays queued until its write has completed.
    assign pop        = (state_reg == DONE);
    // A full queue still accepts a commit when it is draining in the same cycle.
    assign push       = commit && in_range && (!fifo_full || pop);
    assign drop_ovf   = commit && in_range && fifo_full && !pop;
    assign head       = fifo_mem[rd_ptr_reg];

    assign unused_writedata = &{1'b0, bus.kernel_writedata[15:10]};

    // Replace only the addressed 2-bit cell of the returned word; cell k sits at bits [15-2k:14-2k].
    for (genvar gi = 0; gi < 8; gi++) begin : g_cell
        assign merged_word[15-2*gi -: 2] = (work_cell_reg == 3'(gi)) ? work_type_reg
                                                                     : bus.mem_readdata[15-2*gi -: 2];
    end

    // Kernel register writes and the sticky overflow flag (a new drop beats a clear).
    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg        <= '0;
            y_reg        <= '0;
            t_reg        <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (bus.kernel_address)
                    3'd0:    x_reg <= bus.kernel_writedata[9:0];
                    3'd1:    y_reg <= bus.kernel_writedata[8:0];
                    3'd2:    t_reg <= bus.kernel_writedata[1:0];
                    default: ;
                endcase
            end
            if (drop_ovf) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Queue storage, written without reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {x_reg, y_reg, t_reg};
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Latch the head command and its word address when a transaction starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            work_addr_reg <= '0;
            work_cell_reg <= '0;
            work_type_reg <= '0;
        end else if (state_reg == IDLE && !fifo_empty) begin
            work_addr_reg <= BASE_ADDR + (24'(head[10:2]) * 24'd80) + 24'(head[20:14]);
            work_cell_reg <= head[13:11];
            work_type_reg <= head[1:0];
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            mem_req_reg       <= 1'b0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
        end else begin
            state_reg         <= state_next;
            mem_req_reg       <= mem_req_next;
            mem_read_reg      <= mem_read_next;
            mem_write_reg     <= mem_write_next;
            mem_address_reg   <= mem_address_next;
            mem_writedata_reg <= mem_writedata_next;
        end
    end

    // Next state, with outputs decoded from the state being entered so they line up with it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty)            state_next = REQ;
            REQ:     if (bus.mem_grant)          state_next = RD;
            RD:      if (!bus.mem_waitrequest)   state_next = RWAIT;
            RWAIT:   if (bus.mem_readdatavalid)  state_next = WR;
            WR:      if (!bus.mem_waitrequest)   state_next = DONE;
            DONE:                                state_next = IDLE;
            default:                             state_next = IDLE;
        endcase

        mem_req_next       = (state_next != IDLE);
        mem_read_next      = (state_next == RD);
        mem_write_next     = (state_next == WR);
        mem_address_next   = '0;
        mem_writedata_next = '0;
        if (state_next inside {RD, RWAIT, WR}) begin
            mem_address_next = work_addr_reg;
        end
        if (state_next == WR) begin
            mem_writedata_next = (state_reg == RWAIT) ? merged_word : mem_writedata_reg;
        end
    end

    assign bus.mem_req       = mem_req_reg;
    assign bus.mem_read      = mem_read_reg;
    assign bus.mem_write     = mem_write_reg;
    assign bus.mem_address   = mem_address_reg;
    assign bus.mem_writedata = mem_writedata_reg;
    assign busy              = !fifo_empty || (state_reg != IDLE);
    assign overflow          = overflow_reg;
endmodule

// File: tb/tb_sand_spawn.sv
// Bench for sand_spawn: drives kernel commands, emulates the arbiter and the
// SDRAM, and checks every write against a cell-level model of the grid.
`timescale 1ns/1ps
module tb_sand_spawn;
    localparam logic [23:0] BASE  = 24'h001000;
    localparam int          DEPTH = 8;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic overflow;

    sand_spawn_if bus();

    sand_spawn #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Environment knobs and observations
    int  grant_delay = 0, rd_wait = 0, wr_wait = 0;
    bit  grant_enable = 1, rdv_block = 0;
    int  g_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    bit  rdv_pending = 0;
    logic [23:0] rdv_addr;
    int  n_reads = 0, n_writes = 0, early_err = 0, stall_err = 0, req_cycles = 0;
    int  rd_hi = 0, wr_hi = 0;
    bit  prev_stalled = 0;
    logic        prev_rd, prev_wr;
    logic [23:0] prev_addr;
    logic [15:0] prev_wd;
    logic [23:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] sdram [logic [23:0]];

    // Cell-level grid model
    logic [1:0]  cells [int];
    logic [23:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];

    function automatic logic [15:0] init_word(input logic [23:0] a);
        return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        if (sdram.exists(a)) return sdram[a];
        return init_word(a);
    endfunction

    function automatic logic [1:0] get_cell(input int x, input int y);
        logic [15:0] w;
        if (cells.exists(y*640 + x)) return cells[y*640 + x];
        w = init_word(24'(int'(BASE) + y*80 + x/8));
        return w[15 - 2*(x%8) -: 2];
    endfunction

    function automatic logic [15:0] model_word(input int x, input int y);
        logic [15:0] w = 16'h0;
        int x0 = x - (x % 8);
        for (int k = 0; k < 8; k++) w = (w << 2) | 16'(get_cell(x0 + k, y));
        return w;
    endfunction

    task automatic model_commit(input int x, input int y, input int t);
        cells[y*640 + x] = 2'(t);
        exp_addr_q.push_back(24'(int'(BASE) + y*80 + x/8));
        exp_data_q.push_back(model_word(x, y));
    endtask

    // Arbiter + SDRAM responder, acting on the falling edge.
    initial begin
        bus.mem_grant = 0; bus.mem_waitrequest = 0;
        bus.mem_readdatavalid = 0; bus.mem_readdata = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.mem_grant = 0; bus.mem_waitrequest = 0; bus.mem_readdatavalid = 0;
                g_cnt = 0; rd_cnt = 0; wr_cnt = 0; rdv_pending = 0; prev_stalled = 0;
            end else begin
                if ((bus.mem_read || bus.mem_write) && !bus.mem_grant) early_err++;
                if (prev_stalled && (bus.mem_read !== prev_rd || bus.mem_write !== prev_wr ||
                    bus.mem_address !== prev_addr || bus.mem_writedata !== prev_wd)) stall_err++;
                if (bus.mem_req) req_cycles++;
                if (bus.mem_read) rd_hi++;
                if (bus.mem_write) wr_hi++;
                if (!bus.mem_req) begin
                    bus.mem_grant = 0; g_cnt = 0;
                end else if (!bus.mem_grant && grant_enable) begin
                    if (g_cnt >= grant_delay) bus.mem_grant = 1;
                    else g_cnt++;
                end
                if (rdv_pending && !rdv_block) begin
                    bus.mem_readdatavalid = 1; bus.mem_readdata = mem_rd(rdv_addr); rdv_pending = 0;
                end else begin
                    bus.mem_readdatavalid = 0; bus.mem_readdata = 16'($urandom);
                end
                prev_stalled = 0;
                if (bus.mem_read) begin
                    if (rd_cnt < rd_wait) begin
                        bus.mem_waitrequest = 1; rd_cnt++; prev_stalled = 1;
                    end else begin
                        bus.mem_waitrequest = 0; rd_cnt = 0; n_reads++;
                        rdv_pending = 1; rdv_addr = bus.mem_address;
                    end
                end else if (bus.mem_write) begin
                    if (wr_cnt < wr_wait) begin
                        bus.mem_waitrequest = 1; wr_cnt++; prev_stalled = 1;
                    end else begin
                        bus.mem_waitrequest = 0; wr_cnt = 0; n_writes++;
                        sdram[bus.mem_address] = bus.mem_writedata;
                        wr_addr_q.push_back(bus.mem_address);
                        wr_data_q.push_back(bus.mem_writedata);
                        $display("txn write #%0d addr=%06h data=%04h", n_writes, bus.mem_address, bus.mem_writedata);
                    end
                end else begin
                    bus.mem_waitrequest = 1'($urandom_range(0, 1)); rd_cnt = 0; wr_cnt = 0;
                end
                prev_rd = bus.mem_read; prev_wr = bus.mem_write;
                prev_addr = bus.mem_address; prev_wd = bus.mem_writedata;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        bus.kernel_chipselect = 1; bus.kernel_write = 1;
        bus.kernel_address = a; bus.kernel_writedata = d;
        @(negedge clock);
        bus.kernel_chipselect = 1'($urandom_range(0, 1)); bus.kernel_write = 0;
        bus.kernel_address = 3'($urandom); bus.kernel_writedata = 16'($urandom);
    endtask

    task automatic spawn(input int x, input int y, input int t);
        reg_write(3'd0, 16'(x));
        reg_write(3'd1, 16'(y));
        reg_write(3'd2, 16'(t));
        reg_write(3'd3, 16'h0);
    endtask

    task automatic env_setup(input int gd, input int rw, input int ww);
        grant_delay = gd; rd_wait = rw; wr_wait = ww; grant_enable = 1; rdv_block = 0;
        n_reads = 0; n_writes = 0; early_err = 0; stall_err = 0; req_cycles = 0; rd_hi = 0; wr_hi = 0;
        wr_addr_q.delete(); wr_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while ((busy || bus.mem_req) && n < max) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: busy=%0b mem_req=%0b, required 0 within %0d cycles", name, busy, bus.mem_req, max);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clock);
        total++;
        if ({bus.mem_req, bus.mem_read, bus.mem_write} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl: req/read/write=%b required 000", {bus.mem_req, bus.mem_read, bus.mem_write});
        end
        total++;
        if (bus.mem_address !== 24'h0 || bus.mem_writedata !== 16'h0) begin
            bad++; $display("FAIL reset_bus: addr=%h wd=%h required 0", bus.mem_address, bus.mem_writedata);
        end
        total++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_status: busy=%b overflow=%b required 0", busy, overflow);
        end
        reset = 0;
        @(negedge clock);
    endtask

    task automatic test_single_spawn();
        int t_req = -1, t_rd = -1, t_wr = -1, t_idle = -1;
        logic [23:0] rd_addr = '0;
        env_setup(0, 0, 0);
        sdram[BASE + 24'd161] = 16'h0000;
        reg_write(3'd0, 16'd10);
        reg_write(3'd1, 16'd2);
        reg_write(3'd2, 16'd1);
        reg_write(3'd3, 16'h0);
        total++;
        if (busy !== 1'b1 || bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL single_after_commit: busy=%b req=%b required busy=1 req=0", busy, bus.mem_req);
        end
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_req && t_req < 0) t_req = k;
            if (bus.mem_read && t_rd < 0) begin t_rd = k; rd_addr = bus.mem_address; end
            if (bus.mem_write && t_wr < 0) t_wr = k;
            if (!busy && t_idle < 0) t_idle = k;
            @(negedge clock);
        end
        total++;
        if (t_req != 2 || t_rd != 3 || t_wr != 5 || t_idle != 7) begin
            bad++; $display("FAIL single_latency: req/rd/wr/idle at %0d/%0d/%0d/%0d required 2/3/5/7", t_req, t_rd, t_wr, t_idle);
        end
        total++;
        if (rd_addr !== BASE + 24'd161) begin
            bad++; $display("FAIL single_read_addr: got %h required %h", rd_addr, BASE + 24'd161);
        end
        total++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== BASE + 24'd161 || wr_data_q[0] !== 16'h0400) begin
            bad++; $display("FAIL single_write: count=%0d addr=%h data=%h required 1/%h/0400",
                            wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : 24'h0,
                            wr_data_q.size() ? wr_data_q[0] : 16'h0, BASE + 24'd161);
        end
        total++;
        if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_end: req=%b busy=%b required 0", bus.mem_req, busy);
        end
    endtask

    task automatic test_erase();
        env_setup(0, 0, 0);
        sdram[BASE + 24'd38399] = 16'hFFFF;
        spawn(639, 479, 0);
        wait_idle(50, "erase");
        total++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== BASE + 24'd38399 || wr_data_q[0] !== 16'hFFFC) begin
            bad++; $display("FAIL erase_write: count=%0d addr=%h data=%h required 1/%h/fffc",
                            wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : 24'h0,
                            wr_data_q.size() ? wr_data_q[0] : 16'h0, BASE + 24'd38399);
        end
    endtask

    task automatic test_stalls();
        env_setup(5, 3, 3);
        sdram[BASE + 24'd2] = 16'h1234;
        spawn(17, 0, 2);
        wait_idle(100, "stall");
        total++;
        if (early_err != 0 || stall_err != 0) begin
            bad++; $display("FAIL stall_protocol: early=%0d unsteady=%0d required 0/0", early_err, stall_err);
        end
        total++;
        if (n_reads != 1 || n_writes != 1) begin
            bad++; $display("FAIL stall_counts: reads=%0d writes=%0d required 1/1", n_reads, n_writes);
        end
        total++;
        if (rd_hi != 4 || wr_hi != 4) begin
            bad++; $display("FAIL stall_hold: read cycles=%0d write cycles=%0d required 4/4", rd_hi, wr_hi);
        end
        total++;
        if (req_cycles < 11) begin
            bad++; $display("FAIL stall_grant_wait: req cycles=%0d required >=11", req_cycles);
        end
        total++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] !== BASE + 24'd2 || wr_data_q[0] !== 16'h2234) begin
            bad++; $display("FAIL stall_write: addr=%h data=%h required %h/2234",
                            wr_addr_q.size() ? wr_addr_q[0] : 24'h0, wr_data_q.size() ? wr_data_q[0] : 16'h0, BASE + 24'd2);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] expw;
        int errs = 0;
        env_setup(0, 0, 0);
        grant_enable = 0;
        reg_write(3'd0, 16'd5);
        reg_write(3'd1, 16'd20);
        reg_write(3'd2, 16'd3);
        for (int i = 0; i < DEPTH + 2; i++) reg_write(3'd3, 16'h0);
        total++;
        if (overflow !== 1'b1 || n_writes != 0) begin
            bad++; $display("FAIL ovf_set: overflow=%b writes=%0d required 1/0", overflow, n_writes);
        end
        grant_enable = 1;
        wait_idle(600, "ovf");
        cells[20*640 + 5] = 2'd3;
        expw = model_word(5, 20);
        foreach (wr_data_q[i]) if (wr_data_q[i] !== expw || wr_addr_q[i] !== BASE + 24'd1600) errs++;
        total++;
        if (wr_data_q.size() != DEPTH || errs != 0) begin
            bad++; $display("FAIL ovf_drain: writes=%0d wrong=%0d required %0d/0 (data %h)", wr_data_q.size(), errs, DEPTH, expw);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky: overflow=%b required 1", overflow);
        end
        reg_write(3'd4, 16'h0);
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_out_of_range();
        env_setup(0, 0, 0);
        spawn(640, 0, 1);
        repeat (10) @(negedge clock);
        total++;
        if (req_cycles != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL oor_x: req cycles=%0d busy=%b overflow=%b required 0", req_cycles, busy, overflow);
        end
        spawn(3, 480, 1);
        repeat (10) @(negedge clock);
        total++;
        if (req_cycles != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL oor_y: req cycles=%0d busy=%b overflow=%b required 0", req_cycles, busy, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int times[$];
        int errs = 0;
        env_setup(0, 0, 0);
        grant_enable = 0;
        spawn(3, 100, 1);  model_commit(3, 100, 1);
        spawn(11, 100, 2); model_commit(11, 100, 2);
        spawn(4, 100, 3);  model_commit(4, 100, 3);
        grant_enable = 1;
        for (int k = 0; k < 60; k++) begin
            if (bus.mem_write) times.push_back(k);
            @(negedge clock);
        end
        total++;
        if (times.size() != 3 || times[1] - times[0] != 6 || times[2] - times[1] != 6) begin
            bad++; $display("FAIL b2b_spacing: %0d write cycles, gaps %0d/%0d required 3 with gaps 6/6", times.size(),
                            times.size() > 1 ? times[1] - times[0] : -1, times.size() > 2 ? times[2] - times[1] : -1);
        end
        foreach (exp_data_q[i]) if (i >= wr_data_q.size() || wr_data_q[i] !== exp_data_q[i] || wr_addr_q[i] !== exp_addr_q[i]) errs++;
        total++;
        if (wr_data_q.size() != 3 || errs != 0) begin
            bad++; $display("FAIL b2b_data: writes=%0d wrong=%0d required 3/0", wr_data_q.size(), errs);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 3; b++) begin
            int n = $urandom_range(1, DEPTH);
            env_setup($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                int x = $urandom_range(0, 63);
                int y = 10 + $urandom_range(0, 2);
                int t = $urandom_range(0, 3);
                spawn(x, y, t);
                model_commit(x, y, t);
            end
            wait_idle(600, "rand");
            total++;
            if (wr_data_q.size() != n || overflow !== 1'b0 || early_err != 0 || stall_err != 0) begin
                bad++; $display("FAIL rand_batch%0d: writes=%0d overflow=%b early=%0d unsteady=%0d required %0d/0/0/0",
                                b, wr_data_q.size(), overflow, early_err, stall_err, n);
            end
            for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
                total++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    bad++; $display("FAIL rand_txn%0d_%0d: addr=%h data=%h required %h/%h", b, i,
                                    wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        env_setup(0, 0, 0);
        rdv_block = 1;
        spawn(1, 30, 1);
        spawn(9, 30, 2);
        spawn(17, 30, 3);
        while (n_reads == 0 && n < 50) begin @(negedge clock); n++; end
        total++;
        if (n_reads != 1 || busy !== 1'b1 || bus.mem_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid_setup: reads=%0d busy=%b req=%b required 1/1/1", n_reads, busy, bus.mem_req);
        end
        reset = 1;
        @(negedge clock);
        total++;
        if ({bus.mem_req, bus.mem_read, bus.mem_write, busy, overflow} !== 5'b0 ||
            bus.mem_address !== 24'h0 || bus.mem_writedata !== 16'h0) begin
            bad++; $display("FAIL rst_mid_outputs: req=%b rd=%b wr=%b busy=%b addr=%h wd=%h required all 0",
                            bus.mem_req, bus.mem_read, bus.mem_write, busy, bus.mem_address, bus.mem_writedata);
        end
        repeat (2) @(negedge clock);
        reset = 0;
        rdv_block = 0;
        req_cycles = 0;
        n_writes = 0;
        repeat (30) @(negedge clock);
        total++;
        if (req_cycles != 0 || n_writes != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_quiet: req cycles=%0d writes=%0d busy=%b required 0", req_cycles, n_writes, busy);
        end
        // X, Y and T were cleared by reset, so a bare commit erases cell (0, 0).
        env_setup(0, 0, 0);
        reg_write(3'd3, 16'h0);
        model_commit(0, 0, 0);
        wait_idle(50, "rst_mid_commit");
        total++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] !== exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0]) begin
            bad++; $display("FAIL rst_mid_xyt: writes=%0d addr=%h data=%h required 1/%h/%h", wr_data_q.size(),
                            wr_addr_q.size() ? wr_addr_q[0] : 24'h0, wr_data_q.size() ? wr_data_q[0] : 16'h0,
                            exp_addr_q[0], exp_data_q[0]);
        end
    endtask

    initial begin
        reset = 1;
        bus.kernel_chipselect = 0; bus.kernel_write = 0;
        bus.kernel_address = 0; bus.kernel_writedata = 0;
        test_reset();
        test_single_spawn();
        test_erase();
        test_stalls();
        test_overflow();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
